// File: rtl/resv_station.sv
// resv_station: Tomasulo-style reservation station.
//   Holds up to DEPTH in-flight operations. Each entry waits for its two
//   source operands (tracked by producer tags qj/qk; tag 0 = value present),
//   snoops the common data bus for results, and is handed to the function
//   unit once both operands are valid. Dispatch selection is round-robin.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   issue_valid/issue_ready   issue handshake; lowest free entry is written
//   issue_op/qj/qk/vj/vk/tag  issued operation, producer tags, values, dest tag
//   cdb_valid/tag/data        common data bus broadcast (tag 0 is ignored)
//   disp_valid/disp_ready     dispatch handshake to the function unit
//   disp_op/vj/vk/tag         selected entry contents (0 when disp_valid=0)
//   rs_count                  number of busy entries
module resv_station #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [3:0]                 issue_op,
   input  logic [TAG_W-1:0]           issue_qj,
   input  logic [TAG_W-1:0]           issue_qk,
   input  logic [31:0]                issue_vj,
   input  logic [31:0]                issue_vk,
   input  logic [TAG_W-1:0]           issue_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [31:0]                cdb_data,
   output logic                       disp_valid,
   input  logic                       disp_ready,
   output logic [3:0]                 disp_op,
   output logic [31:0]                disp_vj,
   output logic [31:0]                disp_vk,
   output logic [TAG_W-1:0]           disp_tag,
   output logic [$clog2(DEPTH):0]     rs_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0] busy;
   logic [3:0]       op_r  [DEPTH];
   logic [TAG_W-1:0] qj_r  [DEPTH];
   logic [TAG_W-1:0] qk_r  [DEPTH];
   logic [31:0]      vj_r  [DEPTH];
   logic [31:0]      vk_r  [DEPTH];
   logic [TAG_W-1:0] tag_r [DEPTH];
   logic [IDX_W-1:0] last_disp;

   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic [DEPTH-1:0] ready_vec;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] cand;
   logic [CNT_W-1:0] cnt;
   logic             cdb_live;
   logic             issue_fire;
   logic             disp_fire;

   // A tag-0 broadcast would otherwise match every already-valid operand.
   assign cdb_live   = cdb_valid && (cdb_tag != '0);
   assign issue_fire = issue_valid && free_found;
   assign disp_fire  = sel_found && disp_ready;

   // Lowest-index free entry.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!busy[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      ready_vec = '0;
      cnt       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ready_vec[i] = busy[i] && (qj_r[i] == '0) && (qk_r[i] == '0);
         cnt          = cnt + CNT_W'(busy[i]);
      end
   end

   // Round-robin search from last_disp+1; the index wraps naturally because
   // DEPTH is a power of two, and offset DEPTH lands back on last_disp.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         cand = last_disp + IDX_W'(k);
         if (!sel_found && ready_vec[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign issue_ready = free_found;
   assign rs_count    = cnt;
   assign disp_valid  = sel_found;
   assign disp_op     = sel_found ? op_r[sel_idx]  : '0;
   assign disp_vj     = sel_found ? vj_r[sel_idx]  : '0;
   assign disp_vk     = sel_found ? vk_r[sel_idx]  : '0;
   assign disp_tag    = sel_found ? tag_r[sel_idx] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= '0;
         last_disp <= IDX_W'(DEPTH - 1);
         for (int unsigned i = 0; i < DEPTH; i++) begin
            op_r[i]  <= '0;
            qj_r[i]  <= '0;
            qk_r[i]  <= '0;
            vj_r[i]  <= '0;
            vk_r[i]  <= '0;
            tag_r[i] <= '0;
         end
      end else begin
         // CDB snoop on waiting entries.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (busy[i] && cdb_live) begin
               if (qj_r[i] == cdb_tag) begin
                  vj_r[i] <= cdb_data;
                  qj_r[i] <= '0;
               end
               if (qk_r[i] == cdb_tag) begin
                  vk_r[i] <= cdb_data;
                  qk_r[i] <= '0;
               end
            end
         end

         if (disp_fire) begin
            busy[sel_idx] <= 1'b0;
            last_disp     <= sel_idx;
         end

         // The target entry is free, so it never collides with the snoop or
         // dispatch writes above; a same-cycle broadcast is bypassed in.
         if (issue_fire) begin
            busy[free_idx]  <= 1'b1;
            op_r[free_idx]  <= issue_op;
            tag_r[free_idx] <= issue_tag;
            if (cdb_live && issue_qj == cdb_tag) begin
               qj_r[free_idx] <= '0;
               vj_r[free_idx] <= cdb_data;
            end else begin
               qj_r[free_idx] <= issue_qj;
               vj_r[free_idx] <= issue_vj;
            end
            if (cdb_live && issue_qk == cdb_tag) begin
               qk_r[free_idx] <= '0;
               vk_r[free_idx] <= cdb_data;
            end else begin
               qk_r[free_idx] <= issue_qk;
               vk_r[free_idx] <= issue_vk;
            end
         end
      end
   end

endmodule
